// File: rtl/byte_link_pkg.sv
// rtl/byte_link_pkg.sv - shared constants and types for the byte link sender/receiver pair
package byte_link_pkg;

  localparam int BYTE_W         = 8;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_IDLE_LIMIT = 100000000;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous FIFO holding received bytes, push allowed when full if a pop coincides
module byte_fifo
  import byte_link_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = BYTE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign level   = count;

  // Head byte straight from storage; forced to zero while empty so reset reads 0x00.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/byte_link_rx.sv
// rtl/byte_link_rx.sv - byte link receiver: flag synchronizer, edge capture, FIFO, overflow and idle tracking
module byte_link_rx
  import byte_link_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int IDLE_LIMIT = DEF_IDLE_LIMIT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BYTE_W-1:0]             rx_data,
  input  logic                          rx_flag,
  output logic [BYTE_W-1:0]             rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  input  logic                          clr_ovf,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic [BYTE_W-1:0]             last_byte,
  output logic                          link_active
);

  localparam int             CW       = $clog2(IDLE_LIMIT + 1);
  localparam logic [CW-1:0]  IDLE_MAX = CW'(IDLE_LIMIT);

  logic          rst_meta;
  logic          rst_int_n;
  logic          flag_s1;
  logic          flag_s2;
  logic          flag_d;
  logic [1:0]    settle;
  logic          armed;
  logic          capture;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          drop;
  logic [CW-1:0] idle_cnt;

  // Reset asserts immediately, releases only after two clk edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta  <= 1'b0;
      rst_int_n <= 1'b0;
    end else begin
      rst_meta  <= 1'b1;
      rst_int_n <= rst_meta;
    end
  end

  // Two-stage flag synchronizer plus edge register; arming needs a low flag seen after reset.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      flag_s1 <= 1'b0;
      flag_s2 <= 1'b0;
      flag_d  <= 1'b0;
      settle  <= 2'd0;
      armed   <= 1'b0;
    end else begin
      flag_s1 <= rx_flag;
      flag_s2 <= flag_s1;
      flag_d  <= flag_s2;
      if (settle != 2'd2) settle <= settle + 2'd1;
      if (settle == 2'd2 && !flag_s2) armed <= 1'b1;
    end
  end

  // A flag held high across reset release never arms, so it cannot masquerade as a new byte.
  assign capture = armed & flag_s2 & ~flag_d;
  assign pop     = rd_valid & rd_ready;
  assign drop    = capture & fifo_full & ~pop;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_int_n),
    .push      (capture),
    .push_data (rx_data),
    .pop       (pop),
    .pop_data  (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fill_level)
  );

  assign rd_valid = ~fifo_empty;

  // Sticky overflow; a new drop wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)   overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  // Display register follows every capture, dropped bytes included.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)   last_byte <= '0;
    else if (capture) last_byte <= rx_data;
  end

  // Idle counter restarts on capture and saturates at the limit.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n)                idle_cnt <= IDLE_MAX;
    else if (capture)              idle_cnt <= '0;
    else if (idle_cnt < IDLE_MAX)  idle_cnt <= idle_cnt + 1'b1;
  end

  assign link_active = (idle_cnt < IDLE_MAX);

endmodule

// File: tb/tb_byte_link_rx.sv
// tb/tb_byte_link_rx.sv - scoreboard bench for byte_link_rx with a behavioural reference model
module tb_byte_link_rx;

  localparam int DEPTH = 16;
  localparam int LIMIT = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_flag;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       clr_ovf;
  logic       overflow;
  logic [4:0] fill_level;
  logic [7:0] last_byte;
  logic       link_active;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] sb_q [$];
  int         m_level = 0;
  int         m_ovf   = 0;
  int         m_last  = 0;
  int         m_since = LIMIT;
  logic       m_prev  = 1'b1;
  logic [1:0] m_pend  = 2'b00;

  byte_link_rx #(
    .FIFO_DEPTH (DEPTH),
    .IDLE_LIMIT (LIMIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_flag     (rx_flag),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .clr_ovf     (clr_ovf),
    .overflow    (overflow),
    .fill_level  (fill_level),
    .last_byte   (last_byte),
    .link_active (link_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model: a byte is captured two edges after the first edge that sees the flag high
  // following a low sample; a full FIFO with no pop drops it.
  always @(posedge clk) begin
    logic cap;
    logic pop;
    int   lv;
    if (!rst_n) begin
      sb_q.delete();
      m_level = 0;
      m_ovf   = 0;
      m_last  = 0;
      m_since = LIMIT;
      m_prev  = 1'b1;
      m_pend  = 2'b00;
    end else begin
      cap    = m_pend[1];
      m_pend = {m_pend[0], (!m_prev && rx_flag)};
      m_prev = rx_flag;
      lv     = m_level;
      pop    = rd_ready && (lv > 0);
      if (pop) m_level--;
      if (cap) begin
        m_last  = rx_data;
        m_since = 0;
        if (lv == DEPTH && !pop) begin
          m_ovf = 1;
        end else begin
          sb_q.push_back(rx_data);
          m_level++;
          if (clr_ovf) m_ovf = 0;
        end
      end else begin
        if (m_since < LIMIT) m_since++;
        if (clr_ovf) m_ovf = 0;
      end
    end
  end

  // Monitor: compare popped bytes with the scoreboard and status against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_rd_valid", rd_valid, 0);
      check("rst_fill", fill_level, 0);
      check("rst_ovf", overflow, 0);
      check("rst_last", last_byte, 0);
      check("rst_link", link_active, 0);
      check("rst_rd_data", rd_data, 0);
    end else begin
      check("fill_level", fill_level, m_level);
      check("rd_valid", rd_valid, (m_level > 0) ? 1 : 0);
      check("overflow", overflow, m_ovf);
      check("last_byte", last_byte, m_last);
      check("link_active", link_active, (m_since < LIMIT) ? 1 : 0);
      if (rd_valid && rd_ready) begin
        if (sb_q.size() == 0) check("pop_unexpected", 1, 0);
        else check("rd_data", rd_data, sb_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] d, input int hold, input int gap);
    @(posedge clk); #2;
    rx_data = d;
    rx_flag = 1'b1;
    repeat (hold) @(posedge clk);
    #2 rx_flag = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic drain();
    @(posedge clk); #2 rd_ready = 1'b1;
    for (int i = 0; i < 100 && m_level != 0; i++) @(posedge clk);
    #2 rd_ready = 1'b0;
    @(negedge clk);
    check("drain_level", fill_level, 0);
  endtask

  task automatic fill_full();
    for (int i = 0; i < DEPTH; i++) send(8'(8'hA0 + i), 1 + (i % 3), 3);
    @(negedge clk);
    check("full_level", fill_level, DEPTH);
  endtask

  // Start a byte and pulse one control input exactly at its capture edge.
  task automatic send_with_pulse(input logic [7:0] d, input logic use_ready);
    @(posedge clk); #2;
    rx_data = d;
    rx_flag = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    if (use_ready) rd_ready = 1'b1; else clr_ovf = 1'b1;
    @(posedge clk); #2;
    rd_ready = 1'b0;
    clr_ovf  = 1'b0;
    rx_flag  = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_flag  = 1'b0;
    rd_ready = 1'b0;
    clr_ovf  = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(posedge clk);

    // single byte, flag held 4 cycles: latency and one capture
    @(posedge clk); #2;
    rx_data = 8'h5A;
    rx_flag = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("lat_edge2_valid", rd_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_edge3_valid", rd_valid, 1);
    check("lat_rd_data", rd_data, 8'h5A);
    check("lat_last", last_byte, 8'h5A);
    check("lat_link", link_active, 1);
    @(posedge clk);
    #2 rx_flag = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("hold_one_entry", fill_level, 1);
    drain();

    // 17 bytes without reading: last one dropped
    for (int i = 1; i <= 17; i++) send(8'(i), 1 + (i % 4), 3);
    @(negedge clk);
    check("ovf17_level", fill_level, 16);
    check("ovf17_flag", overflow, 1);
    check("ovf17_last", last_byte, 8'h11);
    drain();
    @(posedge clk); #2 clr_ovf = 1'b1;
    @(posedge clk); #2 clr_ovf = 1'b0;
    @(negedge clk);
    check("ovf_cleared", overflow, 0);

    // full FIFO, capture coincident with pop
    fill_full();
    send_with_pulse(8'hC3, 1'b1);
    @(negedge clk);
    check("coinc_level", fill_level, 16);
    check("coinc_ovf", overflow, 0);
    check("coinc_last", last_byte, 8'hC3);
    drain();

    // clr_ovf coincident with a drop
    fill_full();
    send(8'hD1, 2, 3);
    send_with_pulse(8'hD2, 1'b0);
    @(negedge clk);
    check("clr_vs_drop", overflow, 1);
    @(posedge clk); #2 clr_ovf = 1'b1;
    @(posedge clk); #2 clr_ovf = 1'b0;
    @(negedge clk);
    check("clr_alone", overflow, 0);
    drain();

    // idle timeout exactly LIMIT cycles after the capture edge
    repeat (30) @(posedge clk);
    @(posedge clk); #2;
    rx_data = 8'h42;
    rx_flag = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #2 rx_flag = 1'b0;
    repeat (LIMIT - 2) @(posedge clk);
    @(negedge clk);
    check("idle_before_limit", link_active, 1);
    @(posedge clk);
    @(negedge clk);
    check("idle_at_limit", link_active, 0);
    send(8'h77, 2, 3);
    @(negedge clk);
    check("idle_restored", link_active, 1);
    drain();

    // reset with bytes stored and flag held high
    for (int i = 0; i < 5; i++) send(8'(8'h30 + i), 2, 3);
    @(negedge clk);
    check("pre_reset_level", fill_level, 5);
    @(posedge clk); #2;
    rx_data = 8'hEE;
    rx_flag = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("post_reset_level", fill_level, 0);
    check("post_reset_last", last_byte, 0);
    @(posedge clk); #2 rx_flag = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rx_data = 8'h3C;
    rx_flag = 1'b1;
    repeat (4) @(posedge clk);
    #2 rx_flag = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("retoggle_level", fill_level, 1);
    check("retoggle_last", last_byte, 8'h3C);
    drain();

    // randomized traffic: slow reader first, then a faster one
    cnt = 0;
    for (int c = 0; c < 2400; c++) begin
      @(posedge clk); #2;
      rd_ready = (c < 1200) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      clr_ovf  = ($urandom_range(0, 15) == 0);
      if (cnt == 0) begin
        if (rx_flag) begin
          rx_flag = 1'b0;
          cnt = $urandom_range(2, 5);
        end else begin
          rx_flag = 1'b1;
          rx_data = 8'($urandom);
          cnt = $urandom_range(1, 4);
        end
      end
      cnt--;
    end
    @(posedge clk); #2;
    rx_flag  = 1'b0;
    rd_ready = 1'b0;
    clr_ovf  = 1'b0;
    repeat (5) @(posedge clk);
    drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_link_rx.md
BYTE_LINK_RX -- requirements
Module: byte_link_rx

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, byte-FIFO entries (power of two, 4..256).
REQ-002 Parameter IDLE_LIMIT, default 100000000, clk cycles without a captured byte before link_active drops.
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rx_data  input  8  byte from the link sender, stable while rx_flag high.
REQ-006 rx_flag  input  1  send strobe, high for one or more cycles per byte; asynchronous to this block.
REQ-007 rd_data  output  8  FIFO head byte, valid when rd_valid high.
REQ-008 rd_valid  output  1  FIFO not empty.
REQ-009 rd_ready  input  1  consumer accepts head byte when high with rd_valid.
REQ-010 clr_ovf  input  1  one-cycle pulse, clears overflow.
REQ-011 overflow  output  1  sticky flag, set when a byte is dropped because the FIFO is full.
REQ-012 fill_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 last_byte  output  8  most recently captured byte, for LED display.
REQ-014 link_active  output  1  high while a byte was captured within the last IDLE_LIMIT cycles.

Function
REQ-015 rx_flag SHALL pass through a 2-stage synchronizer; a rising edge of the synchronized signal SHALL be one capture event.
REQ-016 Capture SHALL sample rx_data in the same cycle the edge is detected; a flag held high N cycles yields exactly one capture.
REQ-017 Latency: with FIFO empty, rd_valid SHALL rise after the 3rd rising clk edge, counting the first edge at which rx_flag is sampled high.
REQ-018 No bypass: rd_data is driven from FIFO storage only.
REQ-019 Pop occurs on a cycle with rd_valid && rd_ready; rd_ready while empty SHALL be ignored, with no underflow and no level change.
REQ-020 Capture with FIFO full and no pop in the same cycle SHALL drop the byte and set overflow; FIFO contents stay unchanged.
REQ-021 Capture and pop in the same cycle SHALL both take effect, including when full (no overflow) and when at level 1; fill_level is then unchanged.
REQ-022 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fill_level ranges 0..FIFO_DEPTH.
REQ-023 clr_ovf coincident with a new drop SHALL leave overflow set (set wins).
REQ-024 last_byte SHALL update on every capture event, including dropped ones.
REQ-025 Idle counter SHALL reset to 0 on capture, increment otherwise, and saturate at IDLE_LIMIT; link_active = (counter < IDLE_LIMIT).
REQ-026 Idle counter width = $clog2(IDLE_LIMIT+1); it SHALL never wrap.

Reset
REQ-027 rst_n low SHALL immediately clear synchronizer and edge registers, pointers, fill_level=0, rd_valid=0, overflow=0, last_byte=0x00, and set the idle counter to IDLE_LIMIT (link_active=0).
REQ-028 rd_data SHALL read 0x00 in reset; storage contents need not be cleared.
REQ-029 Reset asserted mid-transfer SHALL discard all stored bytes; a rx_flag already high at deassertion SHALL NOT capture until it falls and rises again.
REQ-030 Reset deassertion SHALL be synchronized to clk before the design leaves reset.

Structure
REQ-031 A shared package byte_link_pkg SHALL hold BYTE_W=8, default FIFO_DEPTH and IDLE_LIMIT, shared with the sender side.
REQ-032 A sub-module byte_fifo (parameterized sync FIFO: push, pop, full, empty, level) SHALL hold storage; capture, synchronizer, overflow and idle logic stay in byte_link_rx.

Verification
REQ-033 Reset, rx_data=0x5A, rx_flag high for 4 cycles -> one entry; rd_valid rises at the 3rd edge; rd_data=0x5A; last_byte=0x5A; link_active=1.
REQ-034 17 flag pulses carrying 0x01..0x11 with rd_ready=0 -> fill_level=16, overflow=1, bytes pop 0x01..0x10, last_byte=0x11.
REQ-035 FIFO full, capture coincident with pop -> fill_level stays 16, overflow stays 0, new byte last in order.
REQ-036 IDLE_LIMIT=20 -> link_active falls exactly 20 cycles after the last capture; the next capture restores it.
REQ-037 rst_n pulsed low with 5 bytes stored and rx_flag held high -> fill_level=0, no capture until rx_flag toggles low then high.
REQ-038 clr_ovf in the same cycle as a new drop -> overflow stays 1; clr_ovf alone on a later cycle -> overflow=0.
